// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: registered RV decode/control stage with a valid/ready
// output register, load-use hazard detection and an illegal-opcode trap hold.
// Ports: clk, rst (sync, active high), flush; in_valid/in_ready/in_instr/in_pc
// from IF; out_valid/out_ready plus the registered control bundle to EX;
// trap_pending (TRAP state), stall_count (saturating load-use stall cycles).
// Optional: define CTRL_RV64W_EN (with XLEN=64) to decode OP-IMM-32/OP-32.
module ctrl_decode_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [31:0]      out_instr,
    output logic [2:0]       out_alu_op,
    output logic             out_reg_write,
    output logic             out_alu_src,
    output logic [2:0]       out_mem_read,
    output logic [2:0]       out_mem_write,
    output logic             out_mem_unsigned,
    output logic             out_mem_to_reg,
    output logic             out_branch,
    output logic             out_jump,
    output logic [2:0]       out_inst_type,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic             out_word,
    output logic             out_illegal,
    output logic             trap_pending,
    output logic [CNT_W-1:0] stall_count
);

`ifdef CTRL_RV64W_EN
    localparam logic W_EN = (XLEN == 64);
`else
    localparam logic W_EN = 1'b0;
`endif

    typedef enum logic {
        RUN,
        TRAP
    } state_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       reg_write;
        logic       alu_src;
        logic [2:0] mem_read;
        logic [2:0] mem_write;
        logic       mem_unsigned;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic [2:0] inst_type;
        logic       word;
        logic       illegal;
    } ctrl_t;

    state_t            state_q;
    logic              valid_q;
    ctrl_t             ctrl_q;
    ctrl_t             ctrl_d;
    logic [XLEN-1:0]   pc_q;
    logic [31:0]       instr_q;
    logic [CNT_W-1:0]  stall_q;

    logic [6:0] opc;
    logic [2:0] f3;
    logic       legal;
    logic       use_rs1;
    logic       use_rs2;
    logic       hazard;
    logic       accept;
    logic       stall_inc;

    assign opc = in_instr[6:0];
    assign f3  = in_instr[14:12];

    always_comb begin
        ctrl_d  = '0;
        legal   = 1'b1;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opc)
            7'b0110011: begin
                ctrl_d.alu_op    = 3'b010;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.inst_type = 3'b000;
                use_rs1          = 1'b1;
                use_rs2          = 1'b1;
            end
            7'b0010011: begin
                ctrl_d.alu_op    = 3'b011;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.inst_type = 3'b001;
                use_rs1          = 1'b1;
            end
            7'b0000011: begin
                if (f3 == 3'b111 || (XLEN == 32 && f3 == 3'b011)) begin
                    legal = 1'b0;
                end else begin
                    ctrl_d.reg_write    = 1'b1;
                    ctrl_d.alu_src      = 1'b1;
                    ctrl_d.mem_to_reg   = 1'b1;
                    ctrl_d.mem_read     = {1'b1, f3[1:0]};
                    ctrl_d.mem_unsigned = f3[2];
                    ctrl_d.inst_type    = 3'b001;
                    use_rs1             = 1'b1;
                end
            end
            7'b0100011: begin
                if (f3[2] || (XLEN == 32 && f3 == 3'b011)) begin
                    legal = 1'b0;
                end else begin
                    ctrl_d.alu_src   = 1'b1;
                    ctrl_d.mem_write = {1'b1, f3[1:0]};
                    ctrl_d.inst_type = 3'b010;
                    use_rs1          = 1'b1;
                    use_rs2          = 1'b1;
                end
            end
            7'b1100011: begin
                ctrl_d.alu_op    = 3'b101;
                ctrl_d.branch    = 1'b1;
                ctrl_d.inst_type = 3'b011;
                use_rs1          = 1'b1;
                use_rs2          = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.inst_type = 3'b100;
            end
            7'b1101111: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.jump      = 1'b1;
                ctrl_d.inst_type = 3'b101;
            end
            7'b1100111: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.jump      = 1'b1;
                ctrl_d.inst_type = 3'b001;
                use_rs1          = 1'b1;
            end
            7'b0011011: begin
                if (W_EN) begin
                    ctrl_d.alu_op    = 3'b011;
                    ctrl_d.reg_write = 1'b1;
                    ctrl_d.alu_src   = 1'b1;
                    ctrl_d.inst_type = 3'b001;
                    ctrl_d.word      = 1'b1;
                    use_rs1          = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            7'b0111011: begin
                if (W_EN) begin
                    ctrl_d.alu_op    = 3'b010;
                    ctrl_d.reg_write = 1'b1;
                    ctrl_d.inst_type = 3'b000;
                    ctrl_d.word      = 1'b1;
                    use_rs1          = 1'b1;
                    use_rs2          = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase
        // An illegal word carries no side effects and reads no sources.
        if (!legal) begin
            ctrl_d         = '0;
            ctrl_d.illegal = 1'b1;
            use_rs1        = 1'b0;
            use_rs2        = 1'b0;
        end
    end

    // Load in the output register whose rd feeds the incoming instruction.
    assign hazard = valid_q && ctrl_q.mem_read[2] && (instr_q[11:7] != 5'd0)
                 && ((use_rs1 && in_instr[19:15] == instr_q[11:7])
                  || (use_rs2 && in_instr[24:20] == instr_q[11:7]));

    assign in_ready  = (state_q == RUN) && !flush && !hazard
                    && (!valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign stall_inc = in_valid && hazard && (state_q == RUN) && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            pc_q    <= '0;
            instr_q <= '0;
            stall_q <= '0;
        end else begin
            if (stall_inc && stall_q != '1) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush) begin
                valid_q <= 1'b0;
                state_q <= RUN;
            end else if (accept) begin
                valid_q <= 1'b1;
                ctrl_q  <= ctrl_d;
                pc_q    <= in_pc;
                instr_q <= in_instr;
                if (ctrl_d.illegal) begin
                    state_q <= TRAP;
                end
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_valid        = valid_q;
    assign out_pc           = pc_q;
    assign out_instr        = instr_q;
    assign out_alu_op       = ctrl_q.alu_op;
    assign out_reg_write    = ctrl_q.reg_write;
    assign out_alu_src      = ctrl_q.alu_src;
    assign out_mem_read     = ctrl_q.mem_read;
    assign out_mem_write    = ctrl_q.mem_write;
    assign out_mem_unsigned = ctrl_q.mem_unsigned;
    assign out_mem_to_reg   = ctrl_q.mem_to_reg;
    assign out_branch       = ctrl_q.branch;
    assign out_jump         = ctrl_q.jump;
    assign out_inst_type    = ctrl_q.inst_type;
    assign out_rd           = instr_q[11:7];
    assign out_rs1          = instr_q[19:15];
    assign out_rs2          = instr_q[24:20];
    assign out_word         = ctrl_q.word;
    assign out_illegal      = ctrl_q.illegal;
    assign trap_pending     = (state_q == TRAP);
    assign stall_count      = stall_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb_ctrl_decode_stage: directed bench for ctrl_decode_stage with a
// transaction-level reference model and a per-cycle compare process.
module tb_ctrl_decode_stage;
    localparam int XLEN  = 64;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, out_instr;
    logic [XLEN-1:0] in_pc, out_pc;
    logic [2:0] out_alu_op, out_mem_read, out_mem_write, out_inst_type;
    logic out_reg_write, out_alu_src, out_mem_unsigned, out_mem_to_reg;
    logic out_branch, out_jump, out_word, out_illegal, trap_pending;
    logic [4:0] out_rd, out_rs1, out_rs2;
    logic [CNT_W-1:0] stall_count;

    ctrl_decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .out_alu_op(out_alu_op), .out_reg_write(out_reg_write),
        .out_alu_src(out_alu_src), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_mem_unsigned(out_mem_unsigned),
        .out_mem_to_reg(out_mem_to_reg), .out_branch(out_branch),
        .out_jump(out_jump), .out_inst_type(out_inst_type),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_word(out_word), .out_illegal(out_illegal),
        .trap_pending(trap_pending), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [2:0] alu_op;
        logic       rw;
        logic       asrc;
        logic [2:0] mr;
        logic [2:0] mw;
        logic       mu;
        logic       m2r;
        logic       br;
        logic       jp;
        logic [2:0] ty;
        logic       wd;
        logic       ill;
    } exp_t;

    // Reference decode straight from the opcode table.
    function automatic exp_t ref_dec(input logic [31:0] ins);
        exp_t e;
        logic [2:0] f3;
        bit w64;
        e  = '0;
        f3 = ins[14:12];
`ifdef CTRL_RV64W_EN
        w64 = (XLEN == 64);
`else
        w64 = 1'b0;
`endif
        case (ins[6:0])
            7'h33: begin e.alu_op = 3'd2; e.rw = 1; e.ty = 3'd0; end
            7'h13: begin e.alu_op = 3'd3; e.rw = 1; e.asrc = 1; e.ty = 3'd1; end
            7'h03: begin
                if (f3 == 3'd7 || (XLEN == 32 && f3 == 3'd3)) e.ill = 1;
                else begin
                    e.rw = 1; e.asrc = 1; e.m2r = 1; e.ty = 3'd1;
                    e.mr = {1'b1, f3[1:0]}; e.mu = f3[2];
                end
            end
            7'h23: begin
                if (f3[2] || (XLEN == 32 && f3 == 3'd3)) e.ill = 1;
                else begin e.asrc = 1; e.mw = {1'b1, f3[1:0]}; e.ty = 3'd2; end
            end
            7'h63: begin e.alu_op = 3'd5; e.br = 1; e.ty = 3'd3; end
            7'h37, 7'h17: begin e.rw = 1; e.asrc = 1; e.ty = 3'd4; end
            7'h6F: begin e.rw = 1; e.asrc = 1; e.jp = 1; e.ty = 3'd5; end
            7'h67: begin e.rw = 1; e.asrc = 1; e.jp = 1; e.ty = 3'd1; end
            7'h1B: begin
                if (w64) begin
                    e.alu_op = 3'd3; e.rw = 1; e.asrc = 1; e.ty = 3'd1; e.wd = 1;
                end else e.ill = 1;
            end
            7'h3B: begin
                if (w64) begin e.alu_op = 3'd2; e.rw = 1; e.ty = 3'd0; e.wd = 1; end
                else e.ill = 1;
            end
            default: e.ill = 1;
        endcase
        if (e.ill) begin
            e     = '0;
            e.ill = 1;
        end
        return e;
    endfunction

    // Model state: what EX should currently see.
    bit          m_started = 0;
    bit          m_valid = 0;
    bit          m_trap = 0;
    int unsigned m_stall = 0;
    exp_t        m_b = '0;
    logic [31:0] m_instr = '0;
    logic [63:0] m_pc = '0;

    // Source usage follows the format: R/I/S/B read rs1, R/S/B read rs2.
    function automatic bit m_hazard(input logic [31:0] ins);
        exp_t e;
        bit u1, u2;
        logic [4:0] rd;
        e  = ref_dec(ins);
        rd = m_instr[11:7];
        u1 = !e.ill && (e.ty == 3'd0 || e.ty == 3'd1 || e.ty == 3'd2 || e.ty == 3'd3);
        u2 = !e.ill && (e.ty == 3'd0 || e.ty == 3'd2 || e.ty == 3'd3);
        return m_valid && m_b.mr[2] && rd != 0
            && ((u1 && ins[19:15] == rd) || (u2 && ins[24:20] == rd));
    endfunction

    function automatic bit exp_ready();
        return !m_trap && !flush && !m_hazard(in_instr) && (!m_valid || out_ready);
    endfunction

    always @(posedge clk) begin
        bit acc;
        acc = in_valid && exp_ready();
        m_started <= 1;
        if (rst) begin
            m_valid <= 0; m_trap <= 0; m_stall <= 0;
            m_b <= '0; m_instr <= '0; m_pc <= '0;
        end else if (flush) begin
            m_valid <= 0; m_trap <= 0;
        end else begin
            if (in_valid && !m_trap && m_hazard(in_instr) && m_stall < 65535)
                m_stall <= m_stall + 1;
            if (acc) begin
                m_valid <= 1;
                m_b     <= ref_dec(in_instr);
                m_instr <= in_instr;
                m_pc    <= 64'(in_pc);
                if (ref_dec(in_instr).ill) m_trap <= 1;
            end else if (out_ready) begin
                m_valid <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("valid", out_valid, m_valid);
            chk("in_ready", in_ready, exp_ready());
            chk("trap_pending", trap_pending, m_trap);
            chk("stall_count", stall_count, m_stall);
            if (m_valid) begin
                chk("pc", out_pc, m_pc);
                chk("instr", out_instr, m_instr);
                chk("alu_op", out_alu_op, m_b.alu_op);
                chk("reg_write", out_reg_write, m_b.rw);
                chk("alu_src", out_alu_src, m_b.asrc);
                chk("mem_read", out_mem_read, m_b.mr);
                chk("mem_write", out_mem_write, m_b.mw);
                chk("mem_unsigned", out_mem_unsigned, m_b.mu);
                chk("mem_to_reg", out_mem_to_reg, m_b.m2r);
                chk("branch", out_branch, m_b.br);
                chk("jump", out_jump, m_b.jp);
                chk("inst_type", out_inst_type, m_b.ty);
                chk("word", out_word, m_b.wd);
                chk("illegal", out_illegal, m_b.ill);
                chk("rd", out_rd, m_instr[11:7]);
                chk("rs1", out_rs1, m_instr[19:15]);
                chk("rs2", out_rs2, m_instr[24:20]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins,
                         input logic [63:0] pc);
        in_valid = v;
        in_instr = ins;
        in_pc    = XLEN'(pc);
    endtask

    localparam logic [31:0] ADD3  = 32'h002081B3;
    localparam logic [31:0] LW5   = 32'h0000A283;
    localparam logic [31:0] ADD6  = 32'h00228333;
    localparam logic [31:0] LBU7  = 32'h00014383;
    localparam logic [31:0] LW0   = 32'h0000A003;
    localparam logic [31:0] ADD60 = 32'h00000333;
    localparam logic [31:0] JAL1  = 32'h000000EF;
    localparam logic [31:0] ILL   = 32'h0000007F;
    localparam logic [31:0] ADDIW = 32'h0010809B;
    localparam logic [31:0] SBAD  = 32'h0020C023;

    logic [31:0] vec [8] = '{
        32'h12345237, 32'h00001297, 32'h000280E7, 32'h00208063,
        32'h0020B023, 32'h0001B403, 32'h00140493, 32'h002081BB
    };

    initial begin
        rst = 1; flush = 0; out_ready = 1;
        drive(0, 32'h0, 64'h0);
        tick(); tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_trap", trap_pending, 0);
        chk("rst_stall", stall_count, 0);
        chk("rst_alu_op", out_alu_op, 0);
        chk("rst_pc", out_pc, 0);
        rst = 0;

        drive(1, ADD3, 64'h1000);
        #1 chk("add_in_ready", in_ready, 1);
        tick(); drive(0, ADD3, 64'h1000);
        chk("add_valid", out_valid, 1);
        chk("add_alu_op", out_alu_op, 3'b010);
        chk("add_reg_write", out_reg_write, 1);
        chk("add_type", out_inst_type, 3'b000);
        chk("add_rd", out_rd, 3);
        tick();

        drive(1, LW5, 64'h1004);
        tick(); drive(1, ADD6, 64'h1008);
        #1 chk("ldu_in_ready", in_ready, 0);
        tick();
        chk("ldu_bubble", out_valid, 0);
        chk("ldu_ready_after", in_ready, 1);
        tick(); drive(0, ADD6, 64'h1008);
        chk("ldu_add_valid", out_valid, 1);
        chk("ldu_add_rd", out_rd, 6);
        chk("ldu_stall", stall_count, 1);

        drive(1, LBU7, 64'h100C);
        tick(); drive(1, LW0, 64'h1010);
        chk("lbu_mem_read", out_mem_read, 3'b100);
        chk("lbu_unsigned", out_mem_unsigned, 1);
        chk("lbu_m2r", out_mem_to_reg, 1);
        tick(); drive(1, ADD60, 64'h1014);
        #1 chk("x0_no_stall", in_ready, 1);
        tick(); drive(0, ADD60, 64'h1014);
        chk("x0_add_rd", out_rd, 6);
        chk("x0_stall", stall_count, 1);

        drive(1, JAL1, 64'h2000);
        tick(); drive(1, ADD3, 64'h2004); out_ready = 0;
        #1 chk("hold_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_jump", out_jump, 1);
            chk("hold_pc", out_pc, 64'h2000);
            chk("hold_valid", out_valid, 1);
        end
        out_ready = 1;
        #1 chk("release_ready", in_ready, 1);
        tick(); drive(0, ADD3, 64'h2004);
        chk("release_pc", out_pc, 64'h2004);
        chk("release_jump", out_jump, 0);
        tick();

        drive(1, ILL, 64'h3000);
        tick(); drive(1, ADD3, 64'h3004);
        #1;
        chk("ill_flag", out_illegal, 1);
        chk("ill_rw", out_reg_write, 0);
        chk("ill_mr", out_mem_read, 0);
        chk("ill_mw", out_mem_write, 0);
        chk("ill_trap", trap_pending, 1);
        chk("ill_in_ready", in_ready, 0);
        tick(); tick();
        chk("trap_held", trap_pending, 1);
        flush = 1;
        tick(); flush = 0;
        #1;
        chk("flush_valid", out_valid, 0);
        chk("flush_trap", trap_pending, 0);
        chk("flush_ready", in_ready, 1);
        tick(); drive(0, ADD3, 64'h3004);
        chk("post_flush_rd", out_rd, 3);

        drive(1, ADD6, 64'h4000); flush = 1;
        tick(); flush = 0; drive(0, ADD6, 64'h4000);
        chk("flush_blocks_accept", out_valid, 0);

        drive(1, ADDIW, 64'h5000);
        tick(); drive(0, ADDIW, 64'h5000);
`ifdef CTRL_RV64W_EN
        chk("addiw_type", out_inst_type, 3'b001);
        chk("addiw_word", out_word, 1);
        chk("addiw_ill", out_illegal, 0);
`else
        chk("addiw_ill", out_illegal, 1);
        chk("addiw_trap", trap_pending, 1);
        chk("addiw_word", out_word, 0);
`endif
        flush = 1; tick(); flush = 0;

        for (int i = 0; i < 8; i++) begin
            int n;
            n = 0;
            drive(1, vec[i], 64'h6000 + 64'(i * 4));
            out_ready = (i % 3 != 2);
            #1;
            while (!in_ready && n < 8) begin
                out_ready = 1;
                @(posedge clk); #2;
                n++;
            end
            chk("vec_accept_wait", n < 8, 1);
            tick();
        end
        drive(0, 32'h0, 64'h0); out_ready = 1;
        tick(); flush = 1; tick(); flush = 0;

        drive(1, SBAD, 64'h7000);
        tick(); drive(0, SBAD, 64'h7000);
        chk("sbad_ill", out_illegal, 1);
        chk("sbad_mw", out_mem_write, 0);
        flush = 1; tick(); flush = 0;

        drive(1, LW5, 64'h8000);
        tick(); drive(1, ADD6, 64'h8004);
        tick(); rst = 1; drive(0, ADD6, 64'h8004);
        tick(); rst = 0;
        chk("mid_rst_stall", stall_count, 0);
        chk("mid_rst_valid", out_valid, 0);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ctrl_decode_stage.md
Name: ctrl_decode_stage

Overview:
- Registered, parametrised decode/control stage for the RV pipeline; successor to the combinational opcode control unit.
- Decodes one 32-bit instruction per handshake into the standard control bundle (ALUOp, RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, Branch, Jump, InstType), adding funct3-derived access size, AUIPC, and illegal-opcode detection.
- Holds the result in a valid/ready output register feeding EX.
- Detects load-use hazards against the instruction in the output register, and enters a trap-hold state on illegal opcodes.

Parameters:
- XLEN, 64, datapath/PC width; 32 or 64 only.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- flush  input  1  pipeline flush from EX (redirect or trap entry)
- in_valid  input  1  instruction valid from IF
- in_ready  output  1  stage can accept an instruction
- in_instr  input  32  instruction word
- in_pc  input  XLEN  instruction PC
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  EX accepts the bundle
- out_pc  output  XLEN  registered PC
- out_instr  output  32  registered instruction
- out_alu_op  output  3  R=010, OP-IMM=011, BRANCH=101, all others 000
- out_reg_write  output  1  register-file write enable
- out_alu_src  output  1  ALU operand B selects immediate
- out_mem_read  output  3  bit2 = load enable; bits1:0 = log2 access size (funct3[1:0])
- out_mem_write  output  3  same encoding as out_mem_read, for stores
- out_mem_unsigned  output  1  funct3[2] of a load
- out_mem_to_reg  output  1  writeback from memory
- out_branch  output  1  conditional branch
- out_jump  output  1  JAL/JALR
- out_inst_type  output  3  000 R, 001 I, 010 S, 011 B, 100 U, 101 J
- out_rd, out_rs1, out_rs2  output  5 each  register indices
- out_word  output  1  32-bit word operation (RV64W)
- out_illegal  output  1  illegal or unsupported instruction
- trap_pending  output  1  stage is in the TRAP state
- stall_count  output  CNT_W  load-use stall cycles, saturating

Behaviour:
- Reset: out_valid=0, trap_pending=0, stall_count=0, FSM=RUN. All bundle outputs are 0.
- Decode opcodes:
  - 0110011 R: reg_write=1.
  - 0010011 I: reg_write=1, alu_src=1.
  - 0000011 load: reg_write=1, alu_src=1, mem_to_reg=1, mem_read={1,f3[1:0]}, type I.
  - 0100011 store: alu_src=1, mem_write={1,f3[1:0]}, type S.
  - 1100011 branch: branch=1, type B.
  - 0110111 LUI and 0010111 AUIPC: reg_write=1, alu_src=1, type U.
  - 1101111 JAL: reg_write=1, alu_src=1, jump=1, type J.
  - 1100111 JALR: reg_write=1, alu_src=1, jump=1, type I.
- Illegal: any other opcode; instr[1:0]!=11; load f3 in {011 when XLEN=32, 111}; store f3[2]=1; store f3=011 when XLEN=32. For an illegal instruction, out_illegal=1 and reg_write, mem_read, mem_write, branch, jump, mem_to_reg are all 0.
- Source usage: rs1 is used by R, I, load, store, branch and JALR; rs2 is used by R, store and branch. U and J types use no sources.
- Hazard (combinational): out_valid & out_mem_read[2] & out_rd!=0 & ((uses_rs1 & rs1==out_rd) | (uses_rs2 & rs2==out_rd)).
- in_ready = (FSM==RUN) & !flush & !hazard & (!out_valid | out_ready).
- Accept (in_valid & in_ready): the decoded bundle is registered; out_valid=1 next cycle. Latency is 1 cycle.
- Output register:
  - If out_ready and no accept, out_valid=0 next cycle.
  - If !out_ready, all outputs are held stable.
  - A hazard therefore yields exactly one bubble once the load moves on.
- stall_count increments each cycle that in_valid & hazard & FSM==RUN & !flush; it saturates at 2^CNT_W-1.
- FSM:
  - RUN to TRAP when an illegal instruction is accepted. The illegal bundle is still emitted.
  - TRAP holds in_ready=0 and trap_pending=1.
  - TRAP to RUN only on flush.
- Flush has highest priority over accept, hazard and state: next cycle out_valid=0 and FSM=RUN, with no accept in the flush cycle.
- rst mid-operation: same effect as flush, plus stall_count cleared.

Optional Feature:
- Macro: CTRL_RV64W_EN.
- Defined and XLEN=64:
  - 0011011 decodes as I (alu_op 011), out_word=1.
  - 0111011 decodes as R (alu_op 010), out_word=1.
- Undefined, or XLEN=32: both opcodes are illegal and out_word is tied to 0.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle out_valid=1, alu_op=010, reg_write=1, type=000, rd=3.
- LW x5,0(x1) then ADD x6,x5,x2 back-to-back -> in_ready=0 for 1 cycle, one bubble (out_valid=0), ADD emitted 2 cycles after LW, stall_count=1.
- LBU x7,0(x2) (f3=100) -> mem_read=100, mem_unsigned=1, mem_to_reg=1; LW x0 followed by a use of x0 -> no stall.
- out_ready=0 for 3 cycles while holding JAL -> outputs stable, in_ready=0; release -> JAL transfers, next instruction accepted the same cycle.
- Opcode 0x0000007F -> out_illegal=1, all writes 0, trap_pending=1, in_ready=0; pulse flush -> out_valid=0, trap_pending=0, in_ready=1 next cycle.
- ADDIW (0x0010809B) -> with CTRL_RV64W_EN: type I, word=1; without it: illegal and TRAP entered.
